// File: rtl/commit_trace_arbiter_if.sv
// Bundle of the commit-side retirement inputs and the trace-record stream.
// trace stream: a record moves when trace_valid_o && trace_ready_i at a rising clk; head is held stable while valid && !ready.
interface commit_trace_arbiter_if #(
  parameter int VLEN = 64,
  parameter int TS_W = 32
);
  logic                  en_i;
  logic                  clr_i;
  logic [1:0]            commit_valid_i;
  logic [1:0][VLEN-1:0]  commit_pc_i;
  logic [1:0][31:0]      commit_instr_i;
  logic [1:0][63:0]      commit_wdata_i;
  logic                  ex_valid_i;
  logic [63:0]           ex_cause_i;
  logic [63:0]           ex_tval_i;
  logic                  trace_valid_o;
  logic                  trace_ready_i;
  logic [1:0]            trace_kind_o;
  logic [VLEN-1:0]       trace_pc_o;
  logic [31:0]           trace_instr_o;
  logic [63:0]           trace_data_o;
  logic [63:0]           trace_tval_o;
  logic [TS_W-1:0]       trace_ts_o;
  logic [15:0]           drop_cnt_o;
  logic                  overflow_o;

  modport master (
    output en_i, clr_i, commit_valid_i, commit_pc_i, commit_instr_i, commit_wdata_i,
           ex_valid_i, ex_cause_i, ex_tval_i, trace_ready_i,
    input  trace_valid_o, trace_kind_o, trace_pc_o, trace_instr_o, trace_data_o,
           trace_tval_o, trace_ts_o, drop_cnt_o, overflow_o
  );

  modport slave (
    input  en_i, clr_i, commit_valid_i, commit_pc_i, commit_instr_i, commit_wdata_i,
           ex_valid_i, ex_cause_i, ex_tval_i, trace_ready_i,
    output trace_valid_o, trace_kind_o, trace_pc_o, trace_instr_o, trace_data_o,
           trace_tval_o, trace_ts_o, drop_cnt_o, overflow_o
  );
endinterface

// File: rtl/commit_trace_arbiter.sv
// Serialises up to three retirement events per cycle into a timestamped trace-record FIFO;
// whole cycles that do not fit are dropped and counted so commit never stalls.
module commit_trace_arbiter #(
  parameter int DEPTH = 8,
  parameter int VLEN  = 64,
  parameter int TS_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  commit_trace_arbiter_if.slave tr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]      kind;
    logic [VLEN-1:0] pc;
    logic [31:0]     instr;
    logic [63:0]     data;
    logic [63:0]     tval;
    logic [TS_W-1:0] ts;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, a1, a2;
  logic [CNT_W-1:0] count, free;
  logic [TS_W-1:0]  ts;
  logic [15:0]      drop_cnt;
  logic             overflow;
  logic             w0, w1, w2, drop, admit, valid, pop;
  logic [1:0]       n;
  logic [16:0]      drop_sum;
  rec_t             r0, r1, r2, head;

  always_comb begin
    w0       = tr.en_i & tr.commit_valid_i[0];
    w1       = tr.en_i & tr.commit_valid_i[1];
    w2       = tr.en_i & tr.ex_valid_i;
    n        = {1'b0, w0} + {1'b0, w1} + {1'b0, w2};
    // Space is judged before this cycle's pop so admission never depends on the sink.
    free     = CNT_W'(DEPTH) - count;
    drop     = ({{(CNT_W-2){1'b0}}, n} > free);
    admit    = !drop;
    valid    = (count != '0);
    pop      = valid & tr.trace_ready_i;
    a1       = wr_ptr + PTR_W'(w0);
    a2       = wr_ptr + PTR_W'(w0) + PTR_W'(w1);
    drop_sum = {1'b0, drop_cnt} + 17'(n);
    r0       = '{kind: 2'd0, pc: tr.commit_pc_i[0], instr: tr.commit_instr_i[0],
                 data: tr.commit_wdata_i[0], tval: 64'd0, ts: ts};
    r1       = '{kind: 2'd1, pc: tr.commit_pc_i[1], instr: tr.commit_instr_i[1],
                 data: tr.commit_wdata_i[1], tval: 64'd0, ts: ts};
    r2       = '{kind: 2'd2, pc: tr.commit_pc_i[0], instr: 32'd0,
                 data: tr.ex_cause_i, tval: tr.ex_tval_i, ts: ts};
    head     = mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (admit) begin
      if (w0) mem[wr_ptr] <= r0;
      if (w1) mem[a1]     <= r1;
      if (w2) mem[a2]     <= r2;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (admit) wr_ptr <= wr_ptr + PTR_W'(n);
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + (admit ? CNT_W'(n) : '0) - CNT_W'(pop);
      if (tr.clr_i) begin
        drop_cnt <= drop ? 16'(n) : 16'd0;
        overflow <= drop;
      end else if (drop) begin
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow <= 1'b1;
      end
    end
  end

  // Data outputs read zero whenever no record is presented.
  assign tr.trace_valid_o = valid;
  assign tr.trace_kind_o  = valid ? head.kind  : '0;
  assign tr.trace_pc_o    = valid ? head.pc    : '0;
  assign tr.trace_instr_o = valid ? head.instr : '0;
  assign tr.trace_data_o  = valid ? head.data  : '0;
  assign tr.trace_tval_o  = valid ? head.tval  : '0;
  assign tr.trace_ts_o    = valid ? head.ts    : '0;
  assign tr.drop_cnt_o    = drop_cnt;
  assign tr.overflow_o    = overflow;
endmodule

// File: doc/commit_trace_arbiter.md
Name: commit_trace_arbiter

Overview:
- Collects per-cycle retirement events (two commit ports, one exception) from the commit stage.
- Serialises them in order into a single valid/ready trace-record stream for a trace sink (trace encoder, DPI bridge, on-chip trace buffer).
- Buffers bursts in a small FIFO and timestamps each record.
- Drops whole cycles on overflow and counts the loss, so the sink never stalls commit.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- VLEN, 64, PC width.
- TS_W, 32, timestamp counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  trace enable; when 0 no records are written
- clr_i  in  1  clears drop_cnt_o and overflow_o
- commit_valid_i  in  2  commit acknowledge per port
- commit_pc_i  in  2xVLEN  PC per port
- commit_instr_i  in  2x32  instruction word per port
- commit_wdata_i  in  2x64  write-back data per port
- ex_valid_i  in  1  exception taken this cycle
- ex_cause_i  in  64  exception cause
- ex_tval_i  in  64  exception tval
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  sink accepts head record
- trace_kind_o  out  2  0=COMMIT0, 1=COMMIT1, 2=EXCEPTION
- trace_pc_o  out  VLEN  record PC
- trace_instr_o  out  32  instruction; 0 for exception records
- trace_data_o  out  64  wdata for commits, cause for exceptions
- trace_tval_o  out  64  tval for exceptions, 0 for commits
- trace_ts_o  out  TS_W  timestamp of the cycle the record was captured
- drop_cnt_o  out  16  records dropped, saturating
- overflow_o  out  1  sticky: at least one drop since reset/clear

Behaviour:
- Reset: FIFO empty, rd/wr pointers 0, timestamp 0, drop_cnt_o=0, overflow_o=0, trace_valid_o=0, all trace_* data outputs 0.
- Timestamp: free-running counter, increments every cycle after reset, wraps 2^TS_W-1 -> 0. A record carries the counter value of its capture cycle.
- Records per cycle n = commit_valid_i[0] + commit_valid_i[1] + ex_valid_i, counted only when en_i=1 (range 0..3).
- Write order within a cycle: port0, port1, exception. The exception record PC is commit_pc_i[0].
- commit_valid_i[1] without [0] is legal and yields a single COMMIT1 record.
- Admission is all-or-nothing per cycle. free = DEPTH - count, evaluated before this cycle's pop; a same-cycle pop does not add space.
  - If n <= free: all n records are written.
  - If n > free: none are written; drop_cnt_o += n, saturating at 16'hFFFF; overflow_o set.
- Pop: when trace_valid_o && trace_ready_i, the head advances.
- trace_valid_o = (count != 0). Outputs are driven from the FIFO head, valid in the cycle after the capture edge (1-cycle latency). Head data is stable while valid && !ready.
- Simultaneous push and pop: count' = count + written - popped. Pointers wrap modulo DEPTH.
- clr_i: drop_cnt_o and overflow_o take this cycle's drop contribution only: 0 if nothing is dropped, otherwise n with overflow_o=1. FIFO contents are unaffected.
- en_i deassertion does not flush; already buffered records drain normally.
- Async reset mid-burst: all state returns to reset values immediately. Records in flight are lost and not counted.

Test Plan:
- Reset, then commit_valid_i=2'b01, pc=0x8000_0000, instr=0x0000_0013, wdata=0, trace_ready_i=1 -> one cycle later trace_valid_o=1, kind=0, pc=0x8000_0000, ts=capture value; valid for exactly 1 cycle.
- Same cycle: commit_valid_i=2'b11 (pcs 0x100/0x104), ex_valid_i=1, cause=2, tval=0xdead -> three records in order: kind 0 pc 0x100; kind 1 pc 0x104; kind 2 pc 0x100 data 2 tval 0xdead. All carry the same ts.
- trace_ready_i=0, DEPTH=8, push 2 records/cycle for 4 cycles, then 2 more -> FIFO holds 8; 5th cycle drops both: drop_cnt_o=2, overflow_o=1. Draining yields exactly the first 8 in order.
- Count=7, n=2 with simultaneous pop -> both dropped (drop_cnt_o += 2), count becomes 6.
- Drop counter preloaded to 0xFFFE by repeated overflow, then drop of 3 -> drop_cnt_o=0xFFFF. clr_i with no drop -> 0 and overflow_o=0. clr_i with a drop of 2 -> 2.
- en_i=0 with commits -> no records, no drops. Assert rst_ni low with 5 buffered records -> trace_valid_o=0 immediately; after release the FIFO is empty and ts restarts at 0.
